hi_sim_tx_framer: RTL and testbench

- Upstream stage of the HF tag simulator modulator; its output replaces the SSP-supplied modulation-enable bit.
- Accepts response bytes over a valid/ready handshake and frames them as ISO 14443-A tag-to-reader bits: SOF, 8 data bits LSB first plus odd parity per byte, optional short last byte, EOF.
- Emits a Manchester-coded enable (`mod_out`) at fc/128 bit rate. The downstream modulator ANDs it with the 847.5 kHz subcarrier.

---
 rtl/hi_sim_tx_framer_pkg.sv | 31 +++
 rtl/hi_sim_bit_timer.sv | 37 +++
 rtl/hi_sim_tx_framer.sv | 211 +++++++++++++++++++++
 tb/tb_hi_sim_tx_framer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_sim_tx_framer_pkg.sv
// Shared definitions for the HF tag-simulator transmit framer: state encodings,
// default timing and frame-length helpers.
package hi_sim_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_EOF    = 3'd4
    } tx_state_e;

    // 64 carrier clocks per half bit gives fc/128, i.e. 106 kbit/s.
    localparam int DEFAULT_HALF_BIT = 64;

    localparam int FRAME_SOF_BITS = 1;
    localparam int FRAME_EOF_BITS = 1;
    localparam int FULL_BYTE_BITS = 8;

    // Frame length in carrier clocks for a given number of data and parity bits.
    function automatic int frame_clocks(input int half_bit, input int data_bits,
                                        input int parity_bits);
        return 2 * half_bit * (FRAME_SOF_BITS + data_bits + parity_bits + FRAME_EOF_BITS);
    endfunction

    // Bits actually sent from a byte: a short count only applies to the final byte.
    function automatic logic [3:0] byte_bit_count(input logic last, input logic [2:0] last_bits);
        return (last && last_bits != 3'd0) ? {1'b0, last_bits} : 4'(FULL_BYTE_BITS);
    endfunction

endpackage

// File: rtl/hi_sim_bit_timer.sv
// Bit-period phase counter: wraps every 2*HALF_BIT clocks, held at zero by clear_i,
// and reports whether the phase it will hold next cycle lies in the first half bit.
module hi_sim_bit_timer #(
    parameter  int HALF_BIT = 64,
    localparam int PW       = $clog2(2 * HALF_BIT)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic bit_end_o,
    output logic first_half_nxt_o
);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign bit_end_o = (phase_q == PW'(2 * HALF_BIT - 1));

    always_comb begin
        phase_d = phase_q + PW'(1);
        if (clear_i || bit_end_o) begin
            phase_d = '0;
        end
    end

    // Looking at the next phase lets the framer register mod_out in step with the counter.
    assign first_half_nxt_o = (phase_d < PW'(HALF_BIT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/hi_sim_tx_framer.sv
// ISO 14443-A tag-to-reader framer: takes bytes over valid/ready and emits a registered
// Manchester modulation enable (SOF, LSB-first data, odd parity, optional short last byte, EOF).
module hi_sim_tx_framer
    import hi_sim_tx_framer_pkg::*;
#(
    parameter int HALF_BIT  = DEFAULT_HALF_BIT,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       ck_1356meg,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic [2:0] tx_last_bits,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic       mod_out,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [2:0] dbg_state
);

    // Handshake: a byte moves when tx_valid && tx_ready are both high at a rising edge;
    // tx_valid/tx_data must hold until then, and tx_ready means the holding register is empty.

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] nbits_q, nbits_d;
    logic       par_q, par_d;
    logic       last_q, last_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic [2:0] hold_lbits_q, hold_lbits_d;
    logic       ready_en_q;
    logic       mod_q, mod_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;

    logic accept;
    logic next_byte;
    logic timer_clear;
    logic bit_end;
    logic first_half_nxt;
    logic send_bit;
    logic active;

    assign accept      = tx_valid && tx_ready;
    assign timer_clear = (state_q == ST_IDLE) || abort;

    hi_sim_bit_timer #(
        .HALF_BIT (HALF_BIT)
    ) u_bit_timer (
        .clk_i            (ck_1356meg),
        .rst_n_i          (reset_n),
        .clear_i          (timer_clear),
        .bit_end_o        (bit_end),
        .first_half_nxt_o (first_half_nxt)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        nbits_d      = nbits_q;
        par_d        = par_q;
        last_d       = last_q;
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_lbits_d = hold_lbits_q;
        done_d       = 1'b0;
        underrun_d   = 1'b0;
        next_byte    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    nbits_d = byte_bit_count(tx_last, tx_last_bits);
                    cnt_d   = 4'd0;
                    par_d   = 1'b0;
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                if (bit_end) begin
                    cnt_d   = 4'd0;
                    par_d   = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    par_d   = par_q ^ shift_q[0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == nbits_q - 4'd1) begin
                        if (nbits_q == 4'd8 && PARITY_EN) begin
                            state_d = ST_PARITY;
                        end else begin
                            next_byte = 1'b1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    next_byte = 1'b1;
                end
            end
            ST_EOF: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte boundary: chain straight into the held byte so no idle bit appears.
        if (next_byte) begin
            if (last_q) begin
                state_d = ST_EOF;
            end else if (hold_full_q) begin
                shift_d     = hold_data_q;
                last_d      = hold_last_q;
                nbits_d     = byte_bit_count(hold_last_q, hold_lbits_q);
                cnt_d       = 4'd0;
                par_d       = 1'b0;
                hold_full_d = 1'b0;
                state_d     = ST_DATA;
            end else begin
                underrun_d = 1'b1;
                state_d    = ST_EOF;
            end
        end

        if (accept && state_q != ST_IDLE) begin
            hold_full_d  = 1'b1;
            hold_data_d  = tx_data;
            hold_last_d  = tx_last;
            hold_lbits_d = tx_last_bits;
        end

        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
            done_d      = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    // mod_out is registered from the state/bit/phase that will be current next cycle.
    always_comb begin
        send_bit = 1'b0;
        active   = 1'b1;
        case (state_d)
            ST_SOF:    send_bit = 1'b1;
            ST_DATA:   send_bit = shift_d[0];
            ST_PARITY: send_bit = ~par_d;
            default:   active   = 1'b0;
        endcase
        mod_d = active && (send_bit ? first_half_nxt : !first_half_nxt);
    end

    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            nbits_q      <= '0;
            par_q        <= 1'b0;
            last_q       <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_lbits_q <= '0;
            ready_en_q   <= 1'b0;
            mod_q        <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            nbits_q      <= nbits_d;
            par_q        <= par_d;
            last_q       <= last_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_lbits_q <= hold_lbits_d;
            ready_en_q   <= 1'b1;
            mod_q        <= mod_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_ready  = ready_en_q && !hold_full_q;
    assign mod_out   = mod_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hi_sim_tx_framer.sv
// Bench for hi_sim_tx_framer: frames are described as byte lists, expanded by a
// bit-level reference into the per-clock mod_out waveform and compared bit by bit.
module tb_hi_sim_tx_framer;

    localparam int HB  = 64;
    localparam int BIT = 2 * HB;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [2:0] lb;
    } item_t;

    logic       ck;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [2:0] tx_last_bits;
    logic       tx_valid;
    logic       tx_ready;
    logic       abort;
    logic       mod_out;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [0:0] exp_q[$];
    logic [0:0] cap_q[$];
    item_t      items[$];

    int busy_cnt  = 0;
    int done_cnt  = 0;
    int done_adj  = 0;
    int ur_cnt    = 0;
    int ur_idx    = -1;
    bit prev_busy = 1'b0;

    hi_sim_tx_framer dut (
        .ck_1356meg   (ck),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_last_bits (tx_last_bits),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .abort        (abort),
        .mod_out      (mod_out),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial ck = 1'b0;
    always #5 ck = ~ck;

    // ---------------- monitor ----------------
    always @(negedge ck) begin
        if (underrun) begin
            ur_cnt++;
            ur_idx = busy_cnt;
        end
        if (done) begin
            done_cnt++;
            if (prev_busy && !busy) done_adj++;
        end
        if (busy) begin
            cap_q.push_back(mod_out);
            busy_cnt++;
        end
        prev_busy = busy;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cap_q.delete();
        exp_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_adj = 0;
        ur_cnt   = 0;
        ur_idx   = -1;
    endtask

    // ---------------- reference model ----------------
    task automatic add_bit(input logic b);
        for (int k = 0; k < BIT; k++) exp_q.push_back((k < HB) ? b : ~b);
    endtask

    task automatic model_frame();
        int n;
        int ones;
        add_bit(1'b1);
        foreach (items[i]) begin
            n    = (items[i].l && items[i].lb != 3'd0) ? int'(items[i].lb) : 8;
            ones = 0;
            for (int j = 0; j < n; j++) begin
                ones += int'(items[i].d[j]);
                add_bit(items[i].d[j]);
            end
            if (n == 8) add_bit((ones % 2) == 0);
        end
        for (int k = 0; k < BIT; k++) exp_q.push_back(1'b0);
    endtask

    task automatic compare_bits(input string tag, input int nb);
        logic [127:0] o;
        logic [127:0] e;
        for (int b = 0; b < nb; b++) begin
            o = '0;
            e = '0;
            for (int k = 0; k < BIT; k++) begin
                if (cap_q.size() > 0) o[k] = cap_q.pop_front();
                if (exp_q.size() > 0) e[k] = exp_q.pop_front();
            end
            check_eq($sformatf("%s_bit%0d", tag, b), o, e);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push_byte(input string tag, input logic [7:0] d, input logic l,
                             input logic [2:0] lb);
        int i;
        bit ok;
        ok = 1'b0;
        i  = 0;
        tx_data      = d;
        tx_last      = l;
        tx_last_bits = lb;
        tx_valid     = 1'b1;
        while (!ok && i < 4000) begin
            if (tx_ready === 1'b1) begin
                @(posedge ck);
                ok = 1'b1;
            end
            @(negedge ck);
            i++;
        end
        if (!ok) tx_valid = 1'b0;
        check_eq({tag, "_accept"}, ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20000; i++) begin
            @(negedge ck);
            if (!busy) break;
        end
        check_eq({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge ck);
    endtask

    task automatic run_frame(input string tag);
        int  nb;
        bit  exp_ur;
        clear_mon();
        model_frame();
        exp_ur = !items[items.size() - 1].l;
        for (int k = 0; k < items.size(); k++) begin
            push_byte($sformatf("%s_acc%0d", tag, k), items[k].d, items[k].l, items[k].lb);
            if (k == 1) check_eq({tag, "_rdy_low"}, tx_ready, 0);
        end
        tx_valid = 1'b0;
        wait_idle(tag);
        nb = exp_q.size() / BIT;
        check_eq({tag, "_busy_clks"}, busy_cnt, exp_q.size());
        compare_bits(tag, nb);
        check_eq({tag, "_done"}, done_cnt, 1);
        check_eq({tag, "_done_after_busy"}, done_adj, 1);
        check_eq({tag, "_underrun"}, ur_cnt, exp_ur);
        if (exp_ur) check_eq({tag, "_underrun_at"}, ur_idx, (nb - 1) * BIT);
    endtask

    task automatic add_item(input logic [7:0] d, input logic l, input logic [2:0] lb);
        item_t it;
        it.d  = d;
        it.l  = l;
        it.lb = lb;
        items.push_back(it);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nbytes;
        reset_n      = 1'b0;
        tx_data      = '0;
        tx_last      = 1'b0;
        tx_last_bits = '0;
        tx_valid     = 1'b0;
        abort        = 1'b0;

        #2;
        check_eq("rst_mod_out", mod_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_tx_ready", tx_ready, 0);
        check_eq("rst_state", dbg_state, 0);
        repeat (3) @(negedge ck);
        reset_n = 1'b1;
        @(negedge ck);
        check_eq("rel_tx_ready", tx_ready, 1);

        // Two full bytes with parity: 20 bits.
        items.delete();
        add_item(8'h44, 1'b0, 3'd0);
        add_item(8'h00, 1'b1, 3'd0);
        run_frame("two_byte");

        // Short ACK, 4 bits, no parity.
        items.delete();
        add_item(8'h0A, 1'b1, 3'd4);
        run_frame("ack");

        // Non-last byte with nothing following: underrun then EOF.
        items.delete();
        add_item(8'h01, 1'b0, 3'd0);
        run_frame("underrun");

        // Three bytes streamed back to back: 29 bits, short count on a non-last byte ignored.
        items.delete();
        add_item(8'hA5, 1'b0, 3'd3);
        add_item(8'h3C, 1'b0, 3'd0);
        add_item(8'hF0, 1'b1, 3'd0);
        run_frame("stream3");

        // Abort at phase 30 of data bit 3, with a simultaneous offered byte.
        items.delete();
        add_item(8'hC3, 1'b1, 3'd0);
        clear_mon();
        model_frame();
        push_byte("abort_acc", 8'hC3, 1'b1, 3'd0);
        tx_valid = 1'b0;
        repeat (BIT + 3 * BIT + 30 - 1) @(negedge ck);
        abort        = 1'b1;
        tx_data      = 8'h55;
        tx_last      = 1'b1;
        tx_last_bits = 3'd0;
        tx_valid     = 1'b1;
        @(negedge ck);
        abort    = 1'b0;
        tx_valid = 1'b0;
        check_eq("abort_mod_out", mod_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_tx_ready", tx_ready, 1);
        repeat (300) @(negedge ck);
        check_eq("abort_busy_clks", busy_cnt, BIT + 3 * BIT + 30);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_stays_idle", busy, 0);
        compare_bits("abort", 4);

        items.delete();
        add_item(8'h5A, 1'b1, 3'd0);
        run_frame("after_abort");

        // Asynchronous reset while a data bit drives mod_out high, with a byte held.
        clear_mon();
        push_byte("rstmid_acc0", 8'hA5, 1'b0, 3'd0);
        push_byte("rstmid_acc1", 8'h3C, 1'b1, 3'd0);
        tx_valid = 1'b0;
        repeat (149) @(negedge ck);
        check_eq("rstmid_pre_mod", mod_out, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rstmid_mod_out", mod_out, 0);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_tx_ready", tx_ready, 0);
        repeat (2) @(negedge ck);
        reset_n = 1'b1;
        repeat (2) @(negedge ck);
        items.delete();
        add_item(8'h0A, 1'b1, 3'd4);
        run_frame("after_reset");

        // Random frames of 1..3 bytes.
        for (int f = 0; f < 6; f++) begin
            items.delete();
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++) begin
                add_item(8'($urandom_range(0, 255)), (b == nbytes - 1),
                         3'($urandom_range(0, 7)));
            end
            run_frame($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
